// File: rtl/eink_spi_host.sv
// SPI mode-0 host for the e-ink controller: frames one command per SSEL-low window
// (opcode, argument/pixel bytes) and returns the third MISO byte for PING/STATUS.
module eink_spi_host #(
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int LEAD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  input  logic [7:0]  clip_x1,
  input  logic [7:0]  clip_x2,
  input  logic [9:0]  clip_y1,
  input  logic [9:0]  clip_y2,
  input  logic [17:0] wr_len,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        SSEL,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [2:0] OP_PING = 3'd1, OP_STATUS = 3'd2, OP_WRITE = 3'd3, OP_SET_CLIP = 3'd7;
  localparam logic [15:0] CD_LO  = 16'(CLK_DIV - 1);
  localparam logic [15:0] CD_HI  = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] GAP_END  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] LEAD_END = 16'(LEAD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, TRAIL, POST} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d, idx_q, idx_d;
  logic [17:0] rem_q, rem_d;
  logic [7:0]  sh_q, sh_d, rx_q, rx_d, rd_q, rd_d;
  logic        ssel_q, ssel_d, sck_q, sck_d, mosi_q, mosi_d;
  logic        rdy_q, rdy_d, rv_q, rv_d, pr_q, pr_d, busy_q;
  logic [2:0]  op_q;
  logic [7:0]  arg_q, x1_q, x2_q;
  logic [9:0]  y1_q, y2_q;
  logic        accept, is_write, has_rsp;
  logic [2:0]  last_idx;
  logic [7:0]  nxt_byte;

  assign accept   = cmd_valid && rdy_q && (state_q == IDLE);
  assign is_write = (op_q == OP_WRITE);
  assign has_rsp  = (op_q == OP_PING) || (op_q == OP_STATUS);

  // idx_q is the index of the byte currently on the wire; nxt_byte is the one after it.
  always_comb begin
    nxt_byte = 8'h00;
    last_idx = 3'd1;
    case (op_q)
      OP_PING:   begin last_idx = 3'd2; nxt_byte = (idx_q == 3'd0) ? arg_q : 8'h00; end
      OP_STATUS: last_idx = 3'd2;
      OP_SET_CLIP: begin
        last_idx = 3'd6;
        case (idx_q)
          3'd0:    nxt_byte = x1_q;
          3'd1:    nxt_byte = x2_q;
          3'd2:    nxt_byte = {6'b0, y1_q[9:8]};
          3'd3:    nxt_byte = y1_q[7:0];
          3'd4:    nxt_byte = {6'b0, y2_q[9:8]};
          3'd5:    nxt_byte = y2_q[7:0];
          default: nxt_byte = 8'h00;
        endcase
      end
      default:   nxt_byte = arg_q;
    endcase
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; bit_d = bit_q; idx_d = idx_q; rem_d = rem_q;
    sh_d = sh_q; rx_d = rx_q; rd_d = rd_q;
    ssel_d = ssel_q; sck_d = sck_q; mosi_d = mosi_q; rdy_d = rdy_q;
    rv_d = 1'b0; pr_d = 1'b0;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          state_d = LEAD; cnt_d = '0; bit_d = '0; idx_d = '0; rem_d = wr_len;
          sh_d = {5'b0, cmd_op}; mosi_d = 1'b0; ssel_d = 1'b0; rdy_d = 1'b0;
        end
      end
      LEAD: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LEAD_END) begin state_d = SHIFT; cnt_d = '0; end
      end
      SHIFT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == CD_LO) begin sck_d = 1'b1; rx_d = {rx_q[6:0], MISO}; end
        if (cnt_q == CD_HI) begin
          sck_d = 1'b0; cnt_d = '0; bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (is_write ? (rem_q == '0) : (idx_q == last_idx)) state_d = TRAIL;
            else state_d = GAP;
          end else begin
            sh_d = {sh_q[6:0], 1'b0}; mosi_d = sh_q[6];
          end
        end
      end
      GAP: begin
        // Counter parks at the end of the gap so a pixel stall just stretches it.
        if (cnt_q != GAP_END) cnt_d = cnt_q + 16'd1;
        else if (!is_write || pix_valid) begin
          state_d = SHIFT; cnt_d = '0;
          if (is_write) begin
            sh_d = pix_data; mosi_d = pix_data[7]; rem_d = rem_q - 18'd1; pr_d = 1'b1;
          end else begin
            sh_d = nxt_byte; mosi_d = nxt_byte[7]; idx_d = idx_q + 3'd1;
          end
        end
      end
      TRAIL: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LEAD_END) begin
          state_d = POST; ssel_d = 1'b1; mosi_d = 1'b0; rv_d = has_rsp;
          if (has_rsp) rd_d = rx_q;
        end
      end
      POST: begin state_d = IDLE; rdy_d = 1'b1; end
      default: begin state_d = IDLE; rdy_d = 1'b1; ssel_d = 1'b1; sck_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; cnt_q <= '0; bit_q <= '0; idx_q <= '0; rem_q <= '0;
      sh_q <= '0; rx_q <= '0; rd_q <= '0;
      ssel_q <= 1'b1; sck_q <= 1'b0; mosi_q <= 1'b0;
      rdy_q <= 1'b1; rv_q <= 1'b0; pr_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; bit_q <= bit_d; idx_q <= idx_d; rem_q <= rem_d;
      sh_q <= sh_d; rx_q <= rx_d; rd_q <= rd_d;
      ssel_q <= ssel_d; sck_q <= sck_d; mosi_q <= mosi_d;
      rdy_q <= rdy_d; rv_q <= rv_d; pr_q <= pr_d; busy_q <= ~rdy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0; arg_q <= '0; x1_q <= '0; x2_q <= '0; y1_q <= '0; y2_q <= '0;
    end else if (accept) begin
      op_q <= cmd_op; arg_q <= cmd_arg; x1_q <= clip_x1; x2_q <= clip_x2;
      y1_q <= clip_y1; y2_q <= clip_y2;
    end
  end

  assign cmd_ready = rdy_q;
  assign busy      = busy_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rd_q;
  assign pix_ready = pr_q;
  assign SSEL      = ssel_q;
  assign SCK       = sck_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_eink_spi_host.sv
// Bench for eink_spi_host: SPI slave model, frame-level expectation model and a
// per-cycle monitor, driven by directed command vectors.
module tb_eink_spi_host;
  localparam int CD = 4, G = 16, L = 4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic cmd_valid, cmd_ready, pix_valid, pix_ready, rsp_valid, busy, SSEL, SCK, MOSI;
  logic MISO = 1'b0;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg, clip_x1, clip_x2, pix_data, rsp_data;
  logic [9:0] clip_y1, clip_y2;
  logic [17:0] wr_len;

  eink_spi_host #(.CLK_DIV(CD), .GAP_CYCLES(G), .LEAD_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .clip_x1(clip_x1), .clip_x2(clip_x2),
    .clip_y1(clip_y1), .clip_y2(clip_y2), .wr_len(wr_len), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .SSEL(SSEL), .SCK(SCK), .MOSI(MOSI), .MISO(MISO));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave: echoes byte 1 as byte 2 for PING, returns status as byte 2 for STATUS.
  logic [7:0] rq[$];
  logic [7:0] rxb = 8'h00, tx = 8'h00;
  int nb = 0;
  logic [1:0] s_mode = 2'd2;
  logic s_rdy = 1'b1;
  int sck_rises = 0;

  always @(posedge SCK) sck_rises++;
  always @(negedge SSEL) begin nb = 0; rq.delete(); tx = 8'h00; MISO = 1'b0; end
  always @(posedge SCK) if (!SSEL) begin
    rxb = {rxb[6:0], MOSI}; nb++;
    if (nb % 8 == 0) rq.push_back(rxb);
  end
  always @(negedge SCK) if (!SSEL) begin
    if (nb % 8 == 0) begin
      tx = 8'h00;
      if (nb == 16 && rq[0] == 8'h01) tx = rq[1];
      if (nb == 16 && rq[0] == 8'h02) tx = {5'b0, s_mode, s_rdy};
      MISO = tx[7];
    end else MISO = tx[7 - (nb % 8)];
  end

  // Pixel source: advances on each pix_ready pulse, can withhold one pixel for 100 clocks.
  logic [7:0] pix_arr[4];
  int pix_idx = 0, pix_cnt = 0, stall_before = -1;
  initial begin
    pix_valid = 1'b0; pix_data = 8'h00;
    forever begin
      @(negedge clk);
      if (pix_ready) begin
        pix_idx++; pix_valid = 1'b0;
        if (pix_idx == stall_before) repeat (100) @(negedge clk);
      end
      if (pix_idx < pix_cnt) begin pix_valid = 1'b1; pix_data = pix_arr[pix_idx]; end
      else begin pix_valid = 1'b0; pix_data = 8'hEE; end
    end
  end

  // Frame-level model of what the wire and reply must look like for a command.
  logic [7:0] exp_q[$], last_q[$];
  int exp_win = -1, exp_pix = 0, last_win = 0, done_cnt = 0;
  logic exp_rsp = 1'b0;
  logic [7:0] exp_rdata = 8'h00;

  task automatic model(input logic [2:0] op, input logic [7:0] arg, input logic [7:0] x1, x2,
                       input logic [9:0] y1, y2, input logic [17:0] wl);
    int flen;
    exp_q.delete(); exp_q.push_back({5'b0, op});
    exp_rsp = 1'b0; exp_rdata = 8'h00; exp_pix = 0;
    case (op)
      3'd1: begin exp_q.push_back(arg); exp_q.push_back(8'h00); exp_rsp = 1'b1; exp_rdata = arg; end
      3'd2: begin exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_rsp = 1'b1;
                  exp_rdata = {5'b0, s_mode, s_rdy}; end
      3'd3: begin for (int i = 0; i < int'(wl); i++) exp_q.push_back(pix_arr[i]); exp_pix = int'(wl); end
      3'd7: begin
        exp_q.push_back(x1); exp_q.push_back(x2);
        exp_q.push_back({6'b0, y1[9:8]}); exp_q.push_back(y1[7:0]);
        exp_q.push_back({6'b0, y2[9:8]}); exp_q.push_back(y2[7:0]);
      end
      default: exp_q.push_back(arg);
    endcase
    flen = 2 + 2*L + exp_q.size()*16*CD + (exp_q.size()-1)*G;
    exp_win = flen - 2;  // accept cycle and post-frame idle cycle lie outside SSEL low
  endtask

  logic mon_en = 1'b0, abort = 1'b0, ssel_prev = 1'b1, seen_sck = 1'b0;
  int low_cnt = 0, pr_cnt = 0;

  always @(negedge clk) if (mon_en) begin
    logic rise;
    rise = SSEL && !ssel_prev;
    if (!SSEL && ssel_prev) begin low_cnt = 0; pr_cnt = 0; seen_sck = 1'b0; end
    if (!SSEL) begin
      low_cnt++;
      if (pix_ready) pr_cnt++;
      if (SCK && !seen_sck) begin seen_sck = 1'b1; chk("first_sck_delay", low_cnt, L + CD + 1); end
      chk("ready_low_in_frame", cmd_ready, 1'b0);
    end else chk("sck_idle_low", SCK, 1'b0);
    chk("busy_vs_ready", busy, !cmd_ready);
    chk("rsp_valid", rsp_valid, rise && !abort && exp_rsp);
    if (rise) begin
      done_cnt++; last_q = rq; last_win = low_cnt;
      if (!abort) begin
        chk("frame_bytes", rq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rq.size(); i++)
          chk($sformatf("byte%0d", i), rq[i], exp_q[i]);
        if (exp_win >= 0) chk("ssel_window", low_cnt, exp_win);
        chk("pix_ready_count", pr_cnt, exp_pix);
        if (exp_rsp) chk("rsp_data", rsp_data, exp_rdata);
      end
    end
    ssel_prev = SSEL;
  end

  task automatic send(input logic [2:0] op, input logic [7:0] arg, input logic [7:0] x1, x2,
                      input logic [9:0] y1, y2, input logic [17:0] wl);
    int n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    chk("cmd_ready_before_send", cmd_ready, 1'b1);
    model(op, arg, x1, x2, y1, y2, wl);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; clip_x1 = x1; clip_x2 = x2;
    clip_y1 = y1; clip_y2 = y2; wr_len = wl;
    @(posedge clk); #1;
    // Scramble inputs: the frame must come from the latched copy.
    cmd_valid = 1'b0; cmd_op = 3'd6; cmd_arg = ~arg; clip_x1 = 8'hFF; clip_x2 = 8'h00;
    clip_y1 = 10'h3FF; clip_y2 = 10'h000; wr_len = 18'h3FFFF;
  endtask

  task automatic wait_frame(input int d0, input int lim);
    int n = 0;
    while (done_cnt == d0 && n < lim) begin @(negedge clk); n++; end
    chk("frame_completes", done_cnt != d0, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int d0, r0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'h00; clip_x1 = 8'h00; clip_x2 = 8'h00;
    clip_y1 = 10'h000; clip_y2 = 10'h000; wr_len = 18'd0;
    pix_arr[0] = 8'hC3; pix_arr[1] = 8'h5A; pix_arr[2] = 8'h81; pix_arr[3] = 8'h00;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ssel", SSEL, 1'b1); chk("rst_sck", SCK, 1'b0); chk("rst_mosi", MOSI, 1'b0);
    chk("rst_busy", busy, 1'b0); chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00); chk("rst_pix_ready", pix_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    ssel_prev = SSEL; mon_en = 1'b1;

    // Reset in the middle of the second byte of a SET_CLIP frame.
    abort = 1'b1;
    send(3'd7, 8'h00, 8'd10, 8'd190, 10'h123, 10'h257, 18'd0);
    repeat (120) @(posedge clk);
    chk("sck_active_before_reset", sck_rises > 8, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_ssel", SSEL, 1'b1); chk("async_sck", SCK, 1'b0); chk("async_mosi", MOSI, 1'b0);
    chk("async_busy", busy, 1'b0); chk("async_rsp_valid", rsp_valid, 1'b0);
    chk("async_pix_ready", pix_ready, 1'b0); chk("async_rsp_data", rsp_data, 8'h00);
    r0 = sck_rises;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", cmd_ready, 1'b1);
    repeat (40) @(negedge clk);
    chk("no_sck_after_reset", sck_rises, r0);
    abort = 1'b0;

    // PING echo.
    d0 = done_cnt;
    send(3'd1, 8'hA5, 8'h00, 8'h00, 10'h000, 10'h000, 18'd0);
    wait_frame(d0, 2000);
    chk("ping_rsp_literal", rsp_data, 8'hA5);
    chk("ping_window_literal", last_win, 232);
    chk("ping_mosi_byte1_literal", last_q[1], 8'hA5);

    // STATUS with mode 2, ready 1.
    d0 = done_cnt;
    send(3'd2, 8'h33, 8'h00, 8'h00, 10'h000, 10'h000, 18'd0);
    wait_frame(d0, 2000);
    chk("status_rsp_literal", rsp_data, 8'h05);

    // SET_CLIP complete frame.
    d0 = done_cnt;
    send(3'd7, 8'h00, 8'd10, 8'd190, 10'h123, 10'h257, 18'd0);
    wait_frame(d0, 3000);
    chk("clip_len_literal", last_q.size(), 7);
    chk("clip_x2_literal", last_q[2], 8'hBE);
    chk("clip_y1lo_literal", last_q[4], 8'h23);
    chk("clip_y2lo_literal", last_q[6], 8'h57);
    chk("clip_rsp_hold", rsp_data, 8'h05);

    // WRITE of 3 pixels with the second pixel withheld.
    pix_idx = 0; pix_cnt = 3; stall_before = 1;
    d0 = done_cnt;
    send(3'd3, 8'h00, 8'h00, 8'h00, 10'h000, 10'h000, 18'd3);
    exp_win = -1;
    wait_frame(d0, 5000);
    chk("stall_extends_frame", last_win > 312, 1'b1);
    chk("write_pix1_literal", last_q[2], 8'h5A);

    // WRITE of zero pixels: opcode byte only.
    pix_idx = 0; pix_cnt = 0; stall_before = -1;
    d0 = done_cnt;
    send(3'd3, 8'h00, 8'h00, 8'h00, 10'h000, 10'h000, 18'd0);
    wait_frame(d0, 2000);
    chk("write0_window_literal", last_win, 72);
    chk("write0_len_literal", last_q.size(), 1);

    // DRAW with a stray cmd_valid mid-frame.
    d0 = done_cnt;
    send(3'd4, 8'h3C, 8'h00, 8'h00, 10'h000, 10'h000, 18'd0);
    repeat (60) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_arg = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_frame(d0, 2000);
    d0 = done_cnt;
    repeat (300) @(negedge clk);
    chk("no_extra_frame", done_cnt, d0);
    chk("draw_len_literal", last_q.size(), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
